// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, unsigned/signed, one shift-subtract per cycle
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             smode_q, smode_d;
    logic             sgnq_q, sgnq_d;
    logic             sgnr_q, sgnr_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH+1:0] trial;

    // Negating a W-bit MIN yields 2^(W-1), which is exactly |MIN| read as unsigned,
    // so the magnitude fits in W bits without an extra guard bit.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    assign trial = {a_q, q_q[WIDTH-1]} - {2'b00, m_q};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        smode_d = smode_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        dz_d    = dz_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    smode_d = signed_mode;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                a_d     = '0;
                q_d     = magnitude(dvd_q, smode_q);
                m_d     = magnitude(dvs_q, smode_q);
                cnt_d   = '0;
                sgnq_d  = smode_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                sgnr_d  = smode_q & dvd_q[WIDTH-1];
                dz_d    = (dvs_q == '0);
                state_d = (dvs_q == '0) ? S_FIX : S_ITER;
            end
            S_ITER: begin
                if (!trial[WIDTH+1]) begin
                    a_d = trial[WIDTH:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    a_d = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (dz_q) begin
                    quot_d = ALL_ONES;
                    rem_d  = dvd_q;
                    dbz_d  = 1'b1;
                    ovf_d  = 1'b0;
                end else if (smode_q && dvd_q == MIN_VAL && dvs_q == ALL_ONES) begin
                    quot_d = MIN_VAL;
                    rem_d  = '0;
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = sgnq_q ? -q_q : q_q;
                    rem_d  = sgnr_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            smode_q <= 1'b0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            smode_q <= smode_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            dz_q    <= dz_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed-vector bench for seq_divider at WIDTH=8 and WIDTH=16
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, sm8, rdy8, done8, dz8, ov8;
    logic [7:0] dvd8, dvs8, q8, r8;

    logic        start16, sm16, rdy16, done16, dz16, ov16;
    logic [15:0] dvd16, dvs16, q16, r16;

    int n_pass   = 0;
    int n_checks = 0;

    seq_divider #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .dividend(dvd8), .divisor(dvs8), .quotient(q8), .remainder(r8),
        .ready(rdy8), .done(done8), .div_by_zero(dz8), .overflow(ov8)
    );

    seq_divider #(.WIDTH(16)) u_div16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .dividend(dvd16), .divisor(dvs16), .quotient(q16), .remainder(r16),
        .ready(rdy16), .done(done16), .div_by_zero(dz16), .overflow(ov16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges after the sampling edge at which done was seen.
    task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic early_rdy);
        sm8 = sm; dvd8 = a; dvs8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 0;
        early_rdy = 1'b0;
        while (!done8 && lat < 40) begin
            early_rdy |= rdy8;
            tick();
            lat++;
        end
    endtask

    task automatic op16(input logic sm, input logic [15:0] a, input logic [15:0] b, output int lat);
        sm16 = sm; dvd16 = a; dvs16 = b; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    typedef struct packed {
        logic       sm;
        logic [7:0] a, b, q, r;
        logic       dz, ov;
        logic [7:0] lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic early;
        logic saw;

        vecs[0] = '{1'b0, 8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 8'd10};
        vecs[1] = '{1'b1, 8'h9C,  8'h07,  8'hF2, 8'hFE, 1'b0, 1'b0, 8'd10};
        vecs[2] = '{1'b1, 8'h64,  8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 8'd10};
        vecs[3] = '{1'b1, 8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0, 8'd10};
        vecs[4] = '{1'b0, 8'd7,   8'd0,   8'hFF, 8'h07, 1'b1, 1'b0, 8'd2};
        vecs[5] = '{1'b1, 8'h9C,  8'h00,  8'hFF, 8'h9C, 1'b1, 1'b0, 8'd2};
        vecs[6] = '{1'b0, 8'hFF,  8'h01,  8'hFF, 8'h00, 1'b0, 1'b0, 8'd10};
        vecs[7] = '{1'b1, 8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 8'd10};
        vecs[8] = '{1'b0, 8'h80,  8'hFF,  8'h00, 8'h80, 1'b0, 1'b0, 8'd10};
        vecs[9] = '{1'b1, 8'd7,   8'hFE,  8'hFD, 8'h01, 1'b0, 1'b0, 8'd10};

        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; dvd8 = '0; dvs8 = '0;
        start16 = 1'b0; sm16 = 1'b0; dvd16 = '0; dvs16 = '0;
        tick();
        tick();
        check("rst_q", q8, 0);
        check("rst_r", r8, 0);
        check("rst_ready", rdy8, 1);
        check("rst_done", done8, 0);
        check("rst_dz", dz8, 0);
        check("rst_ov", ov8, 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            op8(vecs[i].sm, vecs[i].a, vecs[i].b, lat, early);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_ready", i), early, 0);
            check($sformatf("v%0d_done_ready", i), rdy8, 1);
            check($sformatf("v%0d_q", i), q8, vecs[i].q);
            check($sformatf("v%0d_r", i), r8, vecs[i].r);
            check($sformatf("v%0d_dz", i), dz8, vecs[i].dz);
            check($sformatf("v%0d_ov", i), ov8, vecs[i].ov);
            tick();
            check($sformatf("v%0d_done_pulse", i), done8, 0);
            check($sformatf("v%0d_hold_q", i), q8, vecs[i].q);
        end

        // Abandon an operation with reset; an ignored start arrives mid-flight first.
        sm8 = 1'b0; dvd8 = 8'd200; dvs8 = 8'd3; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        dvd8 = 8'd50; dvs8 = 8'd5; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        check("busy_hold_r", r8, 8'h01);
        rst = 1'b1;
        #1;
        check("midrst_q", q8, 0);
        check("midrst_r", r8, 0);
        check("midrst_ready", rdy8, 1);
        check("midrst_done", done8, 0);
        tick();
        rst = 1'b0;
        saw = 1'b0;
        repeat (15) begin
            tick();
            saw |= done8;
        end
        check("midrst_no_done", saw, 0);
        op8(1'b0, 8'd200, 8'd3, lat, early);
        check("after_rst_lat", lat, 10);
        check("after_rst_q", q8, 8'd66);
        check("after_rst_r", r8, 8'd2);

        // start held high: second request accepted on the edge closing the done cycle.
        tick();
        sm8 = 1'b0; dvd8 = 8'd50; dvs8 = 8'd5; start8 = 1'b1;
        tick();
        dvd8 = 8'd9; dvs8 = 8'd4;
        lat = 0;
        while (!done8 && lat < 40) begin tick(); lat++; end
        check("b2b_lat1", lat, 10);
        check("b2b_q1", q8, 8'd10);
        check("b2b_r1", r8, 8'd0);
        tick();
        lat++;
        while (!done8 && lat < 60) begin tick(); lat++; end
        start8 = 1'b0;
        check("b2b_lat2", lat, 21);
        check("b2b_q2", q8, 8'd2);
        check("b2b_r2", r8, 8'd1);
        tick();

        op16(1'b0, 16'd60000, 16'd7, lat);
        check("w16_lat", lat, 18);
        check("w16_q", q16, 16'd8571);
        check("w16_r", r16, 16'd3);
        check("w16_dz", dz16, 0);
        tick();
        op16(1'b1, 16'h8AD0, 16'd7, lat);
        check("w16s_lat", lat, 18);
        check("w16s_q", q16, 16'hEF43);
        check("w16s_r", r16, 16'hFFFB);
        check("w16s_ov", ov16, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
